pattern_scan_ctrl: RTL and testbench

Streaming controller that serialises parallel words into a programmable bit-pattern detector and counts hits per stream. It accepts words over a valid/ready handshake and shifts them out MSB first. Pattern, length and overlap mode are runtime-configurable, and the block reports per-bit match pulses, a saturating hit count and an end-of-stream done pulse. It sits in front of the 1011-detector family and generalises it into a scheduled, software-configured scanner.

---
 rtl/pattern_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Serialises DW-bit words MSB first into a runtime-configurable bit-pattern
// detector, counting hits per stream and pulsing done when a stream ends.
module pattern_scan_ctrl #(
    parameter int DW   = 8,
    parameter int PMAX = 8,
    parameter int CW   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cfg_we,
    input  logic [PMAX-1:0]            i_cfg_pattern,
    input  logic [$clog2(PMAX+1)-1:0]  i_cfg_len,
    input  logic                       i_cfg_overlap,
    input  logic                       i_in_valid,
    input  logic [DW-1:0]              i_in_data,
    input  logic                       i_in_last,
    output logic                       o_in_ready,
    output logic                       o_ser_bit,
    output logic                       o_ser_valid,
    output logic                       o_match,
    output logic [CW-1:0]              o_match_count,
    output logic                       o_done,
    output logic                       o_busy
);
    localparam int LW = $clog2(PMAX + 1);
    localparam int BW = $clog2(DW);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [PMAX-1:0] DEF_PATTERN = PMAX'(4'b1011);
    localparam logic [LW-1:0]   DEF_LEN     = LW'(4);
    localparam logic [LW-1:0]   FILL_MAX    = LW'(PMAX);
    localparam logic [CW-1:0]   CNT_MAX     = {CW{1'b1}};

    logic [1:0]      r_state;
    logic            r_open;
    logic            r_last;
    logic            r_match;
    logic [DW-1:0]   r_shreg;
    logic [BW-1:0]   r_bitcnt;
    logic [PMAX-2:0] r_hist;
    logic [LW-1:0]   r_fill;
    logic [CW-1:0]   r_count;
    logic [PMAX-1:0] r_cfg_pattern;
    logic [LW-1:0]   r_cfg_len;
    logic            r_cfg_overlap;

    logic            w_scan;
    logic            w_word_end;
    logic            w_accept;
    logic            w_busy;
    logic            w_cfg_load;
    logic            w_open_stream;
    logic            w_hit;
    logic [PMAX-1:0] w_hist_next;
    logic [PMAX-1:0] w_mask;
    logic [LW-1:0]   w_fill_next;
    logic [LW-1:0]   w_len_eff;

    // Ready depends only on state and bit counter so upstream may wait on it.
    assign w_scan        = (r_state == S_SHIFT);
    assign w_word_end    = w_scan && (r_bitcnt == '0);
    assign o_in_ready    = (r_state == S_IDLE) || (w_word_end && !r_last);
    assign w_accept      = i_in_valid && o_in_ready;
    assign w_busy        = (r_state != S_IDLE) || r_open;
    assign w_cfg_load    = i_cfg_we && !w_busy;
    assign w_open_stream = w_accept && !r_open;

    assign w_len_eff   = (r_cfg_len > FILL_MAX) ? FILL_MAX : r_cfg_len;
    assign w_hist_next = {r_hist, r_shreg[DW-1]};
    assign w_fill_next = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + 1'b1;

    // NOTE: default assignment first, so no path through the block can infer a latch.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PMAX; i++) begin
            w_mask[i] = (LW'(i) < w_len_eff);
        end
    end

    assign w_hit = w_scan && (w_len_eff != '0) && (w_fill_next >= w_len_eff) &&
                   (((w_hist_next ^ r_cfg_pattern) & w_mask) == '0);

    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_open        <= 1'b0;
            r_last        <= 1'b0;
            r_match       <= 1'b0;
            r_shreg       <= '0;
            r_bitcnt      <= '0;
            r_hist        <= '0;
            r_fill        <= '0;
            r_count       <= '0;
            r_cfg_pattern <= DEF_PATTERN;
            r_cfg_len     <= DEF_LEN;
            r_cfg_overlap <= 1'b1;
        end else begin
            r_match <= w_hit;

            case (r_state)
                S_SHIFT: begin
                    r_shreg  <= {r_shreg[DW-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 1'b1;
                    if (w_word_end) begin
                        r_state <= r_last ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    r_open  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // An accepted word overrides the end-of-word transition above.
            if (w_accept) begin
                r_shreg  <= i_in_data;
                r_bitcnt <= BW'(DW - 1);
                r_last   <= i_in_last;
                r_state  <= S_SHIFT;
            end

            if (w_scan) begin
                r_hist <= w_hist_next[PMAX-2:0];
                r_fill <= (w_hit && !r_cfg_overlap) ? '0 : w_fill_next;
                if (w_hit && (r_count != CNT_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            if (w_open_stream) begin
                r_open <= 1'b1;
            end

            if (w_open_stream || w_cfg_load) begin
                r_fill  <= '0;
                r_count <= '0;
            end

            if (w_cfg_load) begin
                r_cfg_pattern <= i_cfg_pattern;
                r_cfg_len     <= i_cfg_len;
                r_cfg_overlap <= i_cfg_overlap;
            end
        end
    end

    assign o_ser_bit     = r_shreg[DW-1];
    assign o_ser_valid   = w_scan;
    assign o_match       = r_match;
    assign o_match_count = r_count;
    assign o_done        = (r_state == S_DONE);
    assign o_busy        = w_busy;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: a bit-level reference model queues
// expected serial bits, match pulses and final counts as words are accepted.
module tb_pattern_scan_ctrl;
    localparam int DW   = 8;
    localparam int PMAX = 8;
    localparam int LW   = $clog2(PMAX + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [PMAX-1:0] cfg_pattern = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic            cfg_overlap = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_last = 1'b0;

    logic        in_ready, ser_bit, ser_valid, match, done, busy;
    logic [15:0] match_count;
    logic        s_in_ready, s_ser_bit, s_ser_valid, s_match, s_done, s_busy;
    logic [1:0]  s_match_count;

    pattern_scan_ctrl #(.DW(DW), .PMAX(PMAX), .CW(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
        .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_in_valid(in_valid),
        .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(in_ready),
        .o_ser_bit(ser_bit), .o_ser_valid(ser_valid), .o_match(match),
        .o_match_count(match_count), .o_done(done), .o_busy(busy)
    );

    pattern_scan_ctrl #(.DW(DW), .PMAX(PMAX), .CW(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
        .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_in_valid(in_valid),
        .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(s_in_ready),
        .o_ser_bit(s_ser_bit), .o_ser_valid(s_ser_valid), .o_match(s_match),
        .o_match_count(s_match_count), .o_done(s_done), .o_busy(s_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int cnt;
    } exp_t;

    bit   exp_bits[$];
    exp_t exp_m[$];
    int   exp_final[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit              m_hist[$];
    int              m_fill;
    int              m_cnt;
    bit              m_open;
    logic [PMAX-1:0] m_pat;
    int              m_len;
    bit              m_ovl;

    bit mon_en = 1'b0;
    bit prev_v = 1'b0;
    int run_len = 0;
    int last_run = 0;

    function automatic int sat(input int c, input int max);
        return (c > max) ? max : c;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_fill = 0;
        m_cnt  = 0;
        m_open = 1'b0;
        m_pat  = PMAX'(4'b1011);
        m_len  = 4;
        m_ovl  = 1'b1;
    endtask

    task automatic model_word(input logic [DW-1:0] d, input logic last);
        int   le;
        bit   b;
        bit   hit;
        exp_t e;
        if (!m_open) begin
            m_open = 1'b1;
            m_fill = 0;
            m_cnt  = 0;
            m_hist.delete();
        end
        le = (m_len > PMAX) ? PMAX : m_len;
        for (int k = DW - 1; k >= 0; k--) begin
            b = d[k];
            m_hist.push_front(b);
            if (m_hist.size() > PMAX) void'(m_hist.pop_back());
            m_fill = (m_fill < PMAX) ? m_fill + 1 : PMAX;
            hit = (le != 0) && (m_fill >= le);
            if (hit) begin
                for (int i = 0; i < le; i++) begin
                    if (m_hist[i] != m_pat[i]) hit = 1'b0;
                end
            end
            if (hit) begin
                m_cnt++;
                if (!m_ovl) m_fill = 0;
            end
            exp_bits.push_back(b);
            e.hit = hit;
            e.cnt = m_cnt;
            exp_m.push_back(e);
        end
        if (last) begin
            m_open = 1'b0;
            exp_final.push_back(m_cnt);
        end
    endtask

    // Output monitor: pops the scoreboard as the DUT produces bits, matches and done.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_v  = 1'b0;
            run_len = 0;
        end else begin
            if (prev_v) begin
                checks++;
                if (exp_m.size() == 0) begin
                    errors++;
                    $display("FAIL match_entry: got match=%0b with no expected entry", match);
                end else begin
                    exp_t e;
                    e = exp_m.pop_front();
                    if (match !== e.hit || match_count !== 16'(e.cnt) ||
                        s_match !== e.hit || s_match_count !== 2'(sat(e.cnt, 3))) begin
                        errors++;
                        $display("FAIL match_bit: got match=%0b count=%0d sat_count=%0d want match=%0b count=%0d sat_count=%0d",
                                 match, match_count, s_match_count, e.hit, e.cnt, sat(e.cnt, 3));
                    end
                end
            end
            if (ser_valid) begin
                checks++;
                run_len++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL ser_bit: got unexpected ser_valid with bit %0b", ser_bit);
                end else begin
                    bit b;
                    b = exp_bits.pop_front();
                    if (ser_bit !== b || s_ser_bit !== b) begin
                        errors++;
                        $display("FAIL ser_bit: got %0b/%0b want %0b", ser_bit, s_ser_bit, b);
                    end
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
            if (done || s_done) begin
                checks++;
                if (exp_final.size() == 0) begin
                    errors++;
                    $display("FAIL done_pulse: got done=%0b/%0b with no stream ending", done, s_done);
                end else begin
                    int c;
                    c = exp_final.pop_front();
                    if (!(done && s_done) || match_count !== 16'(c) || s_match_count !== 2'(sat(c, 3))) begin
                        errors++;
                        $display("FAIL final_count: got done=%0b/%0b count=%0d sat_count=%0d want count=%0d sat_count=%0d",
                                 done, s_done, match_count, s_match_count, c, sat(c, 3));
                    end
                end
            end
            prev_v = ser_valid;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept: in_ready stayed %0b for 64 cycles, want 1", in_ready);
        end else begin
            model_word(d, last);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL done_timeout: got no done in 64 cycles, want one");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [PMAX-1:0] p, input logic [LW-1:0] l,
                             input logic ov, input bit expect_taken);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (expect_taken) begin
            m_pat  = p;
            m_len  = int'(l);
            m_ovl  = ov;
            m_fill = 0;
            m_cnt  = 0;
            m_hist.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || ser_valid !== 1'b0 || match !== 1'b0 || done !== 1'b0 ||
            match_count !== 16'd0 || busy !== 1'b0 || s_match_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%0b sv=%0b m=%0b d=%0b cnt=%0d busy=%0b want 1 0 0 0 0 0",
                     in_ready, ser_valid, match, done, match_count, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_defaults();
        int lat;
        send_word(8'b1011_0110, 1'b1);
        wait_done(lat);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL done_latency: got T+%0d want T+9", lat);
        end
        checks++;
        if (match_count !== 16'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL defaults_overlap: got count=%0d busy=%0b want count=2 busy=0", match_count, busy);
        end
        write_cfg(8'b0000_1011, 4'd4, 1'b0, 1'b1);
        send_word(8'b1011_0110, 1'b1);
        wait_done(lat);
        checks++;
        if (match_count !== 16'd1) begin
            errors++;
            $display("FAIL defaults_nonoverlap: got count=%0d want 1", match_count);
        end
    endtask

    task automatic test_cfg_lock();
        int lat;
        write_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
        send_word(8'b1011_0110, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_midstream: got busy=%0b want 1", busy);
        end
        write_cfg(8'h00, 4'd4, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if (match_count !== 16'd2) begin
            errors++;
            $display("FAIL cfg_ignored: got count=%0d want 2", match_count);
        end
        write_cfg(8'h00, 4'd4, 1'b0, 1'b1);
        checks++;
        if (match_count !== 16'd0) begin
            errors++;
            $display("FAIL cfg_idle_clear: got count=%0d want 0", match_count);
        end
        send_word(8'h00, 1'b1);
        wait_done(lat);
        checks++;
        if (match_count !== 16'd2) begin
            errors++;
            $display("FAIL cfg_idle_taken: got count=%0d want 2", match_count);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        write_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
        send_word(8'b0000_0101, 1'b0);
        send_word(8'b1000_0000, 1'b1);
        wait_done(lat);
        checks++;
        if (last_run != 16 || match_count !== 16'd1) begin
            errors++;
            $display("FAIL boundary_span: got run=%0d count=%0d want run=16 count=1", last_run, match_count);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        logic [LW-1:0] lens[4] = '{4'd3, 4'd3, 4'd15, 4'd0};
        logic [PMAX-1:0] pats[4] = '{8'b111, 8'b111, 8'hFF, 8'b111};
        logic ovls[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int want[4] = '{2, 6, 1, 0};
        for (int t = 0; t < 4; t++) begin
            write_cfg(pats[t], lens[t], ovls[t], 1'b1);
            send_word(8'hFF, 1'b1);
            wait_done(lat);
            checks++;
            if (match_count !== 16'(want[t])) begin
                errors++;
                $display("FAIL all_ones_%0d: got count=%0d want %0d", t, match_count, want[t]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        write_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
        send_word(8'b1011_1011, 1'b0);
        send_word(8'b1011_1011, 1'b1);
        wait_done(lat);
        checks++;
        if (match_count !== 16'd4 || s_match_count !== 2'd3) begin
            errors++;
            $display("FAIL saturation: got count=%0d sat_count=%0d want 4 and 3", match_count, s_match_count);
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        bit seen_done;
        write_cfg(8'h00, 4'd1, 1'b0, 1'b1);
        send_word(8'b1011_0110, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_bits.delete();
        exp_m.delete();
        exp_final.delete();
        model_reset();
        mon_en = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || match_count !== 16'd0 || done !== 1'b0 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got ready=%0b count=%0d done=%0b sv=%0b want 1 0 0 0",
                     in_ready, match_count, done, ser_valid);
        end
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL reset_no_done: got a done pulse after abort, want none");
        end
        @(posedge clk);
        #1;
        send_word(8'b1011_0110, 1'b1);
        wait_done(lat);
        checks++;
        if (lat != 9 || match_count !== 16'd2) begin
            errors++;
            $display("FAIL reset_resend: got lat=%0d count=%0d want 9 and 2", lat, match_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_cfg_lock();
        test_back_to_back();
        test_all_ones();
        test_saturation();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_bits.size() != 0 || exp_m.size() != 0 || exp_final.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d entries left want 0/0/0",
                     exp_bits.size(), exp_m.size(), exp_final.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
